// File: rtl/score_pkg.sv
// Shared types and defaults for the score/HUD digit path.
// Used by both the up-counting score digits and the countdown timer.
package score_pkg;

  localparam int unsigned DEFAULT_DIGIT_WIDTH         = 4;
  localparam int unsigned DEFAULT_MAX_VALUE_PER_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

endpackage

// File: rtl/down_digit.sv
// Single BCD-style digit decrement with borrow ripple.
// Purely combinational; the top level chains one of these per digit.
module down_digit
  import score_pkg::*;
#(
  parameter int unsigned DIGIT_WIDTH         = DEFAULT_DIGIT_WIDTH,
  parameter int unsigned MAX_VALUE_PER_DIGIT = DEFAULT_MAX_VALUE_PER_DIGIT
) (
  input  logic [DIGIT_WIDTH-1:0] digit_i,
  input  logic                   borrow_i,
  output logic [DIGIT_WIDTH-1:0] digit_o,
  output logic                   borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == '0) begin
        digit_o  = DIGIT_WIDTH'(MAX_VALUE_PER_DIGIT);
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - DIGIT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable multi-digit countdown (level timer / lives counter) with prescaled
// automatic steps, external decrement pulses, zero saturation and expiry pulse.
module countdown_timer
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS          = 3,
  parameter int unsigned DIGIT_WIDTH         = DEFAULT_DIGIT_WIDTH,
  parameter int unsigned MAX_VALUE_PER_DIGIT = DEFAULT_MAX_VALUE_PER_DIGIT,
  parameter int unsigned TICKS_PER_STEP      = 50_000_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] load_value,
  input  logic                              run,
  input  logic                              dec_pulse,
  output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] digits,
  output logic                              zero,
  output logic                              expired
);

  localparam int unsigned VALUE_W = NUM_DIGITS * DIGIT_WIDTH;
  localparam int unsigned PRESC_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_STEP - 1);

  timer_state_t        state_q, state_d;
  logic [VALUE_W-1:0]  digits_q, digits_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                zero_q, zero_d;
  logic                expired_q, expired_d;

  logic [VALUE_W-1:0]  load_clamped;
  logic [VALUE_W-1:0]  dec_value;
  logic [NUM_DIGITS:0] borrow;
  logic                value_live;
  logic                tick;
  logic                dec_req;

  // Borrow ripple and per-digit load clamp
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [DIGIT_WIDTH-1:0] ld_digit;

    assign ld_digit = load_value[g*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign load_clamped[g*DIGIT_WIDTH +: DIGIT_WIDTH] =
      (ld_digit > DIGIT_WIDTH'(MAX_VALUE_PER_DIGIT)) ? DIGIT_WIDTH'(MAX_VALUE_PER_DIGIT)
                                                     : ld_digit;

    down_digit #(
      .DIGIT_WIDTH         (DIGIT_WIDTH),
      .MAX_VALUE_PER_DIGIT (MAX_VALUE_PER_DIGIT)
    ) u_down_digit (
      .digit_i  (digits_q[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
      .borrow_i (borrow[g]),
      .digit_o  (dec_value[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
      .borrow_o (borrow[g+1])
    );
  end

  assign value_live = (state_q == RUNNING) || (state_q == PAUSED);
  assign tick       = (state_q == RUNNING) && (presc_q == PRESC_LAST);
  assign dec_req    = tick || (dec_pulse && value_live);

  // Next-state: load beats decrement; a borrow out of the top digit means the
  // value was already zero, so it is never allowed to wrap to all-nines.
  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    if (load) begin
      digits_d = load_clamped;
      presc_d  = '0;
      if (load_clamped != '0) begin
        state_d = run ? RUNNING : PAUSED;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (state_q == RUNNING) begin
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end
      if (dec_req && !borrow[NUM_DIGITS]) begin
        digits_d = dec_value;
        if (dec_value == '0) begin
          state_d   = EXPIRED;
          expired_d = 1'b1;
          presc_d   = '0;
        end else begin
          state_d = run ? RUNNING : PAUSED;
        end
      end else if (value_live) begin
        state_d = run ? RUNNING : PAUSED;
      end
    end

    zero_d = (digits_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      digits_q  <= '0;
      presc_q   <= '0;
      zero_q    <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      presc_q   <= presc_d;
      zero_q    <= zero_d;
      expired_q <= expired_d;
    end
  end

  assign digits  = digits_q;
  assign zero    = zero_q;
  assign expired = expired_q;

endmodule
